turn_controller: RTL and testbench

Turn-sequencing control FSM that sits directly upstream of the game data path. It accepts card picks from the player-input logic, rejects repeated or out-of-range picks, issues one check request per accepted pick and holds the selected card on `position_data`. It consumes the data path's match/win verdict and then either continues the turn, holds a mismatched card face-up and passes the turn to the next player, or ends the game.

---
 rtl/turn_controller.sv | 161 ++++++++++++++++
 tb/tb_turn_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/turn_controller.sv
// Turn-sequencing FSM: validates card picks, issues check requests, consumes the
// match/win verdict and rotates the active player or ends the game.
module turn_controller #(
  parameter int unsigned NUM_CARDS     = 12,
  parameter int unsigned REVEAL_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  N,
  input  logic        pick_valid,
  input  logic [3:0]  pick_card,
  output logic        check_req,
  output logic [3:0]  position_data,
  input  logic        check_done,
  input  logic        same,
  input  logic        win,
  output logic        statecombo_next_turn,
  output logic [1:0]  T,
  output logic [15:0] face_up,
  output logic        reveal,
  output logic        pick_reject,
  output logic        game_over,
  output logic [1:0]  winner
);

  localparam logic [15:0] CardMask   = 16'((32'h1 << NUM_CARDS) - 32'h1);
  localparam logic [25:0] RevealLoad = 26'(REVEAL_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StWaitPick, StCheck, StReveal, StAdvance, StDone
  } state_e;

  state_e      r_state, w_state_nxt;
  logic [1:0]  r_n, w_n_nxt;
  logic [1:0]  r_t, w_t_nxt;
  logic [3:0]  r_pos, w_pos_nxt;
  logic [15:0] r_face, w_face_nxt;
  logic [25:0] r_cnt, w_cnt_nxt;
  logic [1:0]  r_winner, w_winner_nxt;
  logic        r_check_req, w_check_req_nxt;
  logic        r_reject, w_reject_nxt;
  logic        r_next_turn, w_next_turn_nxt;

  logic [15:0] w_pick_onehot;
  logic        w_pick_ok;
  logic        w_mask_full;
  logic [1:0]  w_t_inc;

  // Out-of-range cards map to a zero bit in CardMask, so one lookup covers both refusals.
  assign w_pick_onehot = 16'h1 << pick_card;
  assign w_pick_ok     = CardMask[pick_card] && !r_face[pick_card];
  assign w_mask_full   = ((r_face & CardMask) == CardMask);
  assign w_t_inc       = (r_t == r_n) ? 2'd0 : r_t + 2'd1;

  always_comb begin
    w_state_nxt     = r_state;
    w_n_nxt         = r_n;
    w_t_nxt         = r_t;
    w_pos_nxt       = r_pos;
    w_face_nxt      = r_face;
    w_cnt_nxt       = r_cnt;
    w_winner_nxt    = r_winner;
    w_check_req_nxt = 1'b0;
    w_reject_nxt    = 1'b0;
    w_next_turn_nxt = 1'b0;
    unique case (r_state)
      StIdle, StDone: begin
        if (start) begin
          w_n_nxt     = N;
          w_t_nxt     = 2'd0;
          w_face_nxt  = '0;
          w_state_nxt = StWaitPick;
        end
      end
      StWaitPick: begin
        if (pick_valid) begin
          if (w_pick_ok) begin
            w_face_nxt      = r_face | w_pick_onehot;
            w_pos_nxt       = pick_card;
            w_check_req_nxt = 1'b1;
            w_state_nxt     = StCheck;
          end else begin
            w_reject_nxt = 1'b1;
          end
        end
      end
      StCheck: begin
        if (check_done) begin
          if (win) begin
            w_winner_nxt = r_t;
            w_state_nxt  = StDone;
          end else if (same) begin
            if (w_mask_full) begin
              // Player turned every card; pass the turn without a reveal phase.
              w_t_nxt         = w_t_inc;
              w_next_turn_nxt = 1'b1;
              w_state_nxt     = StAdvance;
            end else begin
              w_state_nxt = StWaitPick;
            end
          end else begin
            w_cnt_nxt   = RevealLoad;
            w_state_nxt = StReveal;
          end
        end
      end
      StReveal: begin
        if (r_cnt == '0) begin
          w_t_nxt         = w_t_inc;
          w_next_turn_nxt = 1'b1;
          w_state_nxt     = StAdvance;
        end else begin
          w_cnt_nxt = r_cnt - 26'd1;
        end
      end
      StAdvance: begin
        w_face_nxt  = '0;
        w_state_nxt = StWaitPick;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_n         <= '0;
      r_t         <= '0;
      r_pos       <= '0;
      r_face      <= '0;
      r_cnt       <= '0;
      r_winner    <= '0;
      r_check_req <= 1'b0;
      r_reject    <= 1'b0;
      r_next_turn <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_n         <= w_n_nxt;
      r_t         <= w_t_nxt;
      r_pos       <= w_pos_nxt;
      r_face      <= w_face_nxt;
      r_cnt       <= w_cnt_nxt;
      r_winner    <= w_winner_nxt;
      r_check_req <= w_check_req_nxt;
      r_reject    <= w_reject_nxt;
      r_next_turn <= w_next_turn_nxt;
    end
  end

  assign check_req            = r_check_req;
  assign position_data        = r_pos;
  assign statecombo_next_turn = r_next_turn;
  assign T                    = r_t;
  assign face_up              = r_face;
  assign reveal               = (r_state == StReveal);
  assign pick_reject          = r_reject;
  assign game_over            = (r_state == StDone);
  assign winner               = r_winner;

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller with NUM_CARDS=12 and REVEAL_CYCLES=4.
module tb_turn_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  N;
  logic        pick_valid;
  logic [3:0]  pick_card;
  logic        check_req;
  logic [3:0]  position_data;
  logic        check_done;
  logic        same;
  logic        win;
  logic        statecombo_next_turn;
  logic [1:0]  T;
  logic [15:0] face_up;
  logic        reveal;
  logic        pick_reject;
  logic        game_over;
  logic [1:0]  winner;

  int n_checks = 0;
  int n_errors = 0;

  turn_controller #(
    .NUM_CARDS    (12),
    .REVEAL_CYCLES(4)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .N                   (N),
    .pick_valid          (pick_valid),
    .pick_card           (pick_card),
    .check_req           (check_req),
    .position_data       (position_data),
    .check_done          (check_done),
    .same                (same),
    .win                 (win),
    .statecombo_next_turn(statecombo_next_turn),
    .T                   (T),
    .face_up             (face_up),
    .reveal              (reveal),
    .pick_reject         (pick_reject),
    .game_over           (game_over),
    .winner              (winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] n);
    start = 1'b1;
    N     = n;
    tick();
    start = 1'b0;
  endtask

  task automatic pick(input logic [3:0] card);
    pick_valid = 1'b1;
    pick_card  = card;
    tick();
    pick_valid = 1'b0;
  endtask

  task automatic verdict(input logic s, input logic w);
    check_done = 1'b1;
    same       = s;
    win        = w;
    tick();
    check_done = 1'b0;
    same       = 1'b0;
    win        = 1'b0;
  endtask

  task automatic count_reveal(output int n);
    n = 0;
    for (int g = 0; g < 20 && reveal; g++) begin
      n++;
      tick();
    end
  endtask

  task automatic mismatch_turn(input logic [3:0] card, input logic [1:0] exp_t);
    int n;
    pick(card);
    verdict(1'b0, 1'b0);
    count_reveal(n);
    chk("mm_reveal_len", 32'(n), 32'd4);
    chk("mm_next_turn", 32'(statecombo_next_turn), 32'd1);
    chk("mm_t", 32'(T), 32'(exp_t));
    tick();
    chk("mm_pulse_end", 32'(statecombo_next_turn), 32'd0);
    chk("mm_face_clr", 32'(face_up), 32'd0);
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    start      = 1'b0;
    N          = 2'd0;
    pick_valid = 1'b0;
    pick_card  = 4'd0;
    check_done = 1'b0;
    same       = 1'b0;
    win        = 1'b0;
    repeat (2) tick();
    chk("rst_t", 32'(T), 32'd0);
    chk("rst_face", 32'(face_up), 32'd0);
    chk("rst_pos", 32'(position_data), 32'd0);
    chk("rst_pulses", 32'({check_req, pick_reject, statecombo_next_turn}), 32'd0);
    chk("rst_flags", 32'({reveal, game_over, winner}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Matching pick keeps the same player.
    do_start(2'd2);
    chk("start_t", 32'(T), 32'd0);
    chk("start_over", 32'(game_over), 32'd0);
    pick(4'd5);
    chk("p5_req", 32'(check_req), 32'd1);
    chk("p5_pos", 32'(position_data), 32'd5);
    chk("p5_face", 32'(face_up), 32'h020);
    verdict(1'b1, 1'b0);
    chk("p5_req_once", 32'(check_req), 32'd0);
    chk("p5_t", 32'(T), 32'd0);
    chk("p5_no_reveal", 32'(reveal), 32'd0);

    // Mismatch: four reveal cycles then the turn passes.
    pick(4'd3);
    chk("p3_face", 32'(face_up), 32'h028);
    verdict(1'b0, 1'b0);
    count_reveal(n);
    chk("p3_reveal_len", 32'(n), 32'd4);
    chk("p3_next_turn", 32'(statecombo_next_turn), 32'd1);
    chk("p3_t", 32'(T), 32'd1);
    tick();
    chk("p3_pulse_end", 32'(statecombo_next_turn), 32'd0);
    chk("p3_face_clr", 32'(face_up), 32'd0);

    // Wrap-around with three players.
    mismatch_turn(4'd0, 2'd2);
    mismatch_turn(4'd0, 2'd0);

    // Refused picks and ignored start.
    pick(4'd7);
    verdict(1'b1, 1'b0);
    chk("p7_face", 32'(face_up), 32'h080);
    pick(4'd7);
    chk("rep_reject", 32'(pick_reject), 32'd1);
    chk("rep_no_req", 32'(check_req), 32'd0);
    chk("rep_face", 32'(face_up), 32'h080);
    tick();
    chk("rep_pulse_end", 32'(pick_reject), 32'd0);
    pick(4'd13);
    chk("oor_reject", 32'(pick_reject), 32'd1);
    chk("oor_no_req", 32'(check_req), 32'd0);
    chk("oor_face", 32'(face_up), 32'h080);
    do_start(2'd0);
    chk("start_ign_t", 32'(T), 32'd0);
    chk("start_ign_face", 32'(face_up), 32'h080);

    // pick_valid during CHECK is ignored.
    pick(4'd2);
    pick(4'd4);
    chk("chk_no_reject", 32'(pick_reject), 32'd0);
    chk("chk_no_req", 32'(check_req), 32'd0);
    chk("chk_face", 32'(face_up), 32'h084);
    verdict(1'b1, 1'b0);

    // Fill the whole mask with matches; last verdict goes straight to ADVANCE.
    for (int c = 0; c < 12; c++) begin
      if (c != 2 && c != 7) begin
        pick(4'(c));
        if (c == 11) chk("full_face", 32'(face_up), 32'hFFF);
        verdict(1'b1, 1'b0);
      end
    end
    chk("full_next_turn", 32'(statecombo_next_turn), 32'd1);
    chk("full_no_reveal", 32'(reveal), 32'd0);
    chk("full_t", 32'(T), 32'd1);
    tick();
    chk("full_face_clr", 32'(face_up), 32'd0);

    // Win overrides a mismatch.
    pick(4'd4);
    verdict(1'b0, 1'b1);
    chk("win_over", 32'(game_over), 32'd1);
    chk("win_winner", 32'(winner), 32'd1);
    chk("win_no_reveal", 32'(reveal), 32'd0);
    tick();
    chk("win_hold", 32'(game_over), 32'd1);

    // Restart from DONE, then reset asynchronously in the middle of a reveal.
    do_start(2'd1);
    chk("restart_over", 32'(game_over), 32'd0);
    chk("restart_t", 32'(T), 32'd0);
    mismatch_turn(4'd6, 2'd1);
    pick(4'd9);
    verdict(1'b0, 1'b0);
    tick();
    chk("pre_rst_reveal", 32'(reveal), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_reveal", 32'(reveal), 32'd0);
    chk("arst_t", 32'(T), 32'd0);
    chk("arst_face", 32'(face_up), 32'd0);
    chk("arst_pos", 32'(position_data), 32'd0);
    chk("arst_winner", 32'(winner), 32'd0);
    chk("arst_pulses", 32'({check_req, pick_reject, statecombo_next_turn, game_over}), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
